// File: rtl/fetch_queue.sv
// Dual-lane instruction fetch queue between fetch and decode (DEPTH pairs, FIFO order).
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward a fetched pair straight to decode.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ValidF,
  input  logic                   ValidF2,
  input  logic [31:0]            InstrF1,
  input  logic [31:0]            PCF1,
  input  logic [31:0]            PCPlus8F1,
  input  logic [31:0]            InstrF2,
  input  logic [31:0]            PCF2,
  input  logic [31:0]            PCPlus8F2,
  input  logic                   ReadyD,
  input  logic                   Flush,
  output logic                   FullF,
  output logic                   ValidD1,
  output logic                   ValidD2,
  output logic [31:0]            InstrD1,
  output logic [31:0]            PCD1,
  output logic [31:0]            PCPlus8D1,
  output logic [31:0]            InstrD2,
  output logic [31:0]            PCD2,
  output logic [31:0]            PCPlus8D2,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        v2;
    logic [31:0] i1;
    logic [31:0] p1;
    logic [31:0] n1;
    logic [31:0] i2;
    logic [31:0] p2;
    logic [31:0] n2;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  entry_t          w_fentry;
  entry_t          w_head;
  logic            w_empty;
  logic            w_full;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  assign w_fentry = {ValidF2, InstrF1, PCF1, PCPlus8F1, InstrF2, PCF2, PCPlus8F2};
  assign w_head   = r_mem[r_rptr];
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & ValidF & ReadyD & ~Flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed pair is consumed by decode directly, so it is neither stored nor popped.
  assign w_push = ValidF & ~w_full & ~Flush & ~w_bypass;
  assign w_pop  = ReadyD & ~w_empty & ~Flush;

  assign FullF = w_full;
  assign Count = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (Flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; the empty check below keeps stale entries hidden.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_fentry;
  end

  always_comb begin
    ValidD1   = 1'b0;
    ValidD2   = 1'b0;
    InstrD1   = NOP;
    PCD1      = '0;
    PCPlus8D1 = '0;
    InstrD2   = NOP;
    PCD2      = '0;
    PCPlus8D2 = '0;
    if (!w_empty) begin
      ValidD1   = 1'b1;
      ValidD2   = w_head.v2;
      InstrD1   = w_head.i1;
      PCD1      = w_head.p1;
      PCPlus8D1 = w_head.n1;
      InstrD2   = w_head.v2 ? w_head.i2 : NOP;
      PCD2      = w_head.p2;
      PCPlus8D2 = w_head.n2;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (w_bypass) begin
      ValidD1   = 1'b1;
      ValidD2   = ValidF2;
      InstrD1   = InstrF1;
      PCD1      = PCF1;
      PCPlus8D1 = PCPlus8F1;
      InstrD2   = ValidF2 ? InstrF2 : NOP;
      PCD2      = PCF2;
      PCPlus8D2 = PCPlus8F2;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected pairs queued on accepted push, compared at the head.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        vd1;
    logic        v2;
    logic [31:0] i1;
    logic [31:0] p1;
    logic [31:0] n1;
    logic [31:0] i2;
    logic [31:0] p2;
    logic [31:0] n2;
  } pair_t;

  logic clk, rst, ValidF, ValidF2, ReadyD, Flush;
  logic [31:0] InstrF1, PCF1, PCPlus8F1, InstrF2, PCF2, PCPlus8F2;
  logic FullF, ValidD1, ValidD2;
  logic [31:0] InstrD1, PCD1, PCPlus8D1, InstrD2, PCD2, PCPlus8D2;
  logic [CW-1:0] Count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ValidF(ValidF), .ValidF2(ValidF2),
    .InstrF1(InstrF1), .PCF1(PCF1), .PCPlus8F1(PCPlus8F1),
    .InstrF2(InstrF2), .PCF2(PCF2), .PCPlus8F2(PCPlus8F2),
    .ReadyD(ReadyD), .Flush(Flush), .FullF(FullF),
    .ValidD1(ValidD1), .ValidD2(ValidD2),
    .InstrD1(InstrD1), .PCD1(PCD1), .PCPlus8D1(PCPlus8D1),
    .InstrD2(InstrD2), .PCD2(PCD2), .PCPlus8D2(PCPlus8D2),
    .Count(Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  pair_t sb[$];
  pair_t fpair;

  function automatic pair_t mk(input logic [31:0] pc, input logic v2);
    pair_t p;
    p.vd1 = 1'b1;
    p.v2  = v2;
    p.i1  = $urandom;
    p.p1  = pc;
    p.n1  = pc + 32'd8;
    p.i2  = $urandom;
    p.p2  = pc + 32'd4;
    p.n2  = pc + 32'd12;
    return p;
  endfunction

  function automatic pair_t act_head();
    return {ValidD1, ValidD2, InstrD1, PCD1, PCPlus8D1, InstrD2, PCD2, PCPlus8D2};
  endfunction

  function automatic pair_t exp_head();
    pair_t e;
    e    = '0;
    e.i1 = NOP;
    e.i2 = NOP;
    if (sb.size() > 0) e = sb[0];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (sb.size() == 0 && ValidF && ReadyD && !Flush) e = fpair;
`endif
    if (!e.v2) e.i2 = NOP;
    return e;
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are observed at the falling edge.
  task automatic drive(input logic vf, input pair_t p, input logic rd, input logic fl);
    ValidF    = vf;
    ValidF2   = p.v2;
    InstrF1   = p.i1;
    PCF1      = p.p1;
    PCPlus8F1 = p.n1;
    InstrF2   = p.i2;
    PCF2      = p.p2;
    PCPlus8F2 = p.n2;
    ReadyD    = rd;
    Flush     = fl;
    fpair     = p;
    #4;
  endtask

  task automatic step();
    bit push, pop, byp;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && ValidF && ReadyD && !Flush;
`endif
    push = ValidF && (sb.size() < DEPTH) && !Flush && !byp;
    pop  = ReadyD && (sb.size() > 0) && !Flush;
    @(posedge clk);
    if (!rst || Flush) begin
      sb.delete();
    end else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back(fpair);
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, mk(32'h100, 1'b1), 1'b1, 1'b1);
    step();
    drive(1'b1, mk(32'h108, 1'b1), 1'b0, 1'b0);
    step();
    rst = 1'b1;
    idle();
    tests++;
    if (Count !== '0) begin
      fails++; $display("FAIL reset_count: got %0d expected 0", Count);
    end
    tests++;
    if (FullF !== 1'b0) begin
      fails++; $display("FAIL reset_full: got %b expected 0", FullF);
    end
    tests++;
    if (act_head() !== exp_head()) begin
      fails++; $display("FAIL reset_head: got %h expected %h", act_head(), exp_head());
    end
    step();
  endtask

  task automatic test_fill();
    logic [31:0] pcs [4] = '{32'h0, 32'h8, 32'h10, 32'h18};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(32'(i * 8), 1'b1), 1'b0, 1'b0);
      step();
    end
    idle();
    tests++;
    if (Count !== CW'(3) || PCD1 !== 32'h0 || FullF !== 1'b0) begin
      fails++; $display("FAIL fill3: got count=%0d pcd1=%h full=%b expected count=3 pcd1=0 full=0", Count, PCD1, FullF);
    end
    step();
    drive(1'b1, mk(32'h18, 1'b1), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(32'h20, 1'b1), 1'b0, 1'b0);
    tests++;
    if (FullF !== 1'b1 || Count !== CW'(4)) begin
      fails++; $display("FAIL fill4_full: got full=%b count=%0d expected full=1 count=4", FullF, Count);
    end
    step();
    idle();
    tests++;
    if (Count !== CW'(4) || Count !== CW'(sb.size())) begin
      fails++; $display("FAIL fill5_ignored: got count=%0d expected 4", Count);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0);
      tests++;
      if (PCD1 !== pcs[k] || act_head() !== exp_head()) begin
        fails++; $display("FAIL pop_order[%0d]: got pcd1=%h head=%h expected pcd1=%h head=%h", k, PCD1, act_head(), pcs[k], exp_head());
      end
      step();
    end
    idle();
    tests++;
    if (Count !== '0 || ValidD1 !== 1'b0) begin
      fails++; $display("FAIL drained: got count=%0d vd1=%b expected count=0 vd1=0", Count, ValidD1);
    end
    step();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, mk(32'h200 + 32'(i * 8), 1'b1), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, mk(32'h300, 1'b1), 1'b1, 1'b0);
    tests++;
    if (FullF !== 1'b1) begin
      fails++; $display("FAIL full_before: got %b expected 1", FullF);
    end
    step();
    idle();
    tests++;
    if (Count !== CW'(3) || FullF !== 1'b0 || PCD1 !== 32'h208) begin
      fails++; $display("FAIL full_push_pop: got count=%0d full=%b pcd1=%h expected count=3 full=0 pcd1=208", Count, FullF, PCD1);
    end
    step();
    drive(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1);
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk(32'h300 + 32'(i * 8), 1'b1), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, mk(32'h380, 1'b1), 1'b1, 1'b1);
    tests++;
    if (Count !== CW'(2)) begin
      fails++; $display("FAIL flush_pre: got %0d expected 2", Count);
    end
    step();
    idle();
    tests++;
    if (Count !== '0 || ValidD1 !== 1'b0 || InstrD1 !== NOP || act_head() !== exp_head()) begin
      fails++; $display("FAIL flush: got count=%0d vd1=%b instr1=%h expected count=0 vd1=0 instr1=%h", Count, ValidD1, InstrD1, NOP);
    end
    step();
  endtask

  task automatic test_lane2_wrap();
    pair_t p;
    p    = mk(32'h400, 1'b0);
    p.i2 = 32'hDEAD_BEEF;
    drive(1'b1, p, 1'b0, 1'b0);
    step();
    idle();
    tests++;
    if (ValidD1 !== 1'b1 || ValidD2 !== 1'b0 || InstrD2 !== NOP) begin
      fails++; $display("FAIL lane2_invalid: got vd1=%b vd2=%b instr2=%h expected vd1=1 vd2=0 instr2=%h", ValidD1, ValidD2, InstrD2, NOP);
    end
    step();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, mk(32'h500 + 32'(i * 8), 1'($urandom_range(0, 1))), 1'b1, 1'b0);
      tests++;
      if (act_head() !== exp_head()) begin
        fails++; $display("FAIL wrap[%0d]: got %h expected %h", i, act_head(), exp_head());
      end
      step();
    end
    idle();
    tests++;
    if (Count !== CW'(1) || PCD1 !== 32'h558) begin
      fails++; $display("FAIL wrap_end: got count=%0d pcd1=%h expected count=1 pcd1=558", Count, PCD1);
    end
    step();
    drive(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1);
    step();
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0);
      step();
    end
    idle();
    tests++;
    if (Count !== '0 || ValidD1 !== 1'b0) begin
      fails++; $display("FAIL underflow: got count=%0d vd1=%b expected 0 0", Count, ValidD1);
    end
    drive(1'b1, mk(32'h600, 1'b1), 1'b0, 1'b0);
    step();
    idle();
    tests++;
    if (PCD1 !== 32'h600 || act_head() !== exp_head()) begin
      fails++; $display("FAIL underflow_ptr: got %h expected %h", act_head(), exp_head());
    end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk(32'h680 + 32'(i * 8), 1'b1), 1'b0, 1'b0);
      step();
    end
    rst = 1'b0;
    drive(1'b1, mk(32'h6F0, 1'b1), 1'b1, 1'b1);
    step();
    rst = 1'b1;
    idle();
    tests++;
    if (Count !== '0 || ValidD1 !== 1'b0 || FullF !== 1'b0 || InstrD1 !== NOP) begin
      fails++; $display("FAIL reset_mid: got count=%0d vd1=%b full=%b instr1=%h expected 0 0 0 %h", Count, ValidD1, FullF, InstrD1, NOP);
    end
    step();
  endtask

  task automatic test_bypass();
    pair_t p;
    p    = mk(32'h700, 1'b1);
    p.i1 = 32'h0050_0093;
    drive(1'b1, p, 1'b1, 1'b0);
    tests++;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (ValidD1 !== 1'b1 || InstrD1 !== 32'h0050_0093) begin
      fails++; $display("FAIL bypass_same: got vd1=%b instr1=%h expected 1 00500093", ValidD1, InstrD1);
    end
`else
    if (ValidD1 !== 1'b0) begin
      fails++; $display("FAIL bypass_same: got vd1=%b expected 0", ValidD1);
    end
`endif
    step();
    idle();
    tests++;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (Count !== '0 || ValidD1 !== 1'b0) begin
      fails++; $display("FAIL bypass_next: got count=%0d vd1=%b expected 0 0", Count, ValidD1);
    end
`else
    if (Count !== CW'(1) || ValidD1 !== 1'b1 || InstrD1 !== 32'h0050_0093) begin
      fails++; $display("FAIL bypass_next: got count=%0d vd1=%b instr1=%h expected 1 1 00500093", Count, ValidD1, InstrD1);
    end
`endif
    step();
    drive(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1);
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 3) != 0), mk(32'h1000 + 32'(i * 8), 1'($urandom_range(0, 1))),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      tests++;
      if (act_head() !== exp_head() || Count !== CW'(sb.size()) || FullF !== (sb.size() == DEPTH)) begin
        fails++; $display("FAIL random[%0d]: got head=%h count=%0d full=%b expected head=%h count=%0d", i, act_head(), Count, FullF, exp_head(), sb.size());
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_full_push_pop();
    test_flush();
    test_lane2_wrap();
    test_underflow();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
